pipelined_shifter: RTL and testbench
====================================

// Module: pipelined_shifter
// PURPOSE
//   Parametrised, fully pipelined barrel shifter for the CPU execute path.
//   Supports SLL, SRL, SRA and an optional rotate-right mode.
//   Operates on WIDTH-bit operands with one register stage per shift-amount bit.
//   Uses a valid/ready handshake so the ALU/MDU issue logic can stream one op per cycle.
// PARAMETERS
//   WIDTH    32               operand/result width; power of two, >= 4
//   SHAMT_W  $clog2(WIDTH)    shift-amount width; also pipeline depth (stages)
// PORTS
//   clock          in   1        rising-edge clock
//   reset          in   1        synchronous, active-high reset
//   in_valid       in   1        operand/control valid this cycle
//   in_ready       out  1        shifter accepts input this cycle
//   data_operandA  in   WIDTH    value to shift
//   ctrl_shiftamt  in   SHAMT_W  shift amount, 0..WIDTH-1
//   ctrl_mode      in   2        00 SLL, 01 SRL, 10 SRA, 11 ROR (see CONFIGURATION)
//   out_valid      out  1        data_result valid
//   out_ready      in   1        consumer accepts result this cycle
//   data_result    out  WIDTH    shifted result
// BEHAVIOUR
//   - Stage k (k=0..SHAMT_W-1) shifts by 2^k iff shamt bit k set; LSB stage first.
//   - Each stage register holds: data, shamt, mode, valid bit.
//   - Output of the last stage drives data_result/out_valid directly.
//   - Global advance enable: adv = out_ready | ~out_valid.
//   - in_ready = adv (combinational); transfer in = in_valid & in_ready.
//   - Transfer out = out_valid & out_ready.
//   - When adv=1, all stages shift forward one position; stage 0 loads input.
//     Stage 0 valid = in_valid.
//   - When adv=0, all stage registers (data and valid) hold; data_result stable.
//   - Bubbles are not collapsed while stalled.
//   - Latency: exactly SHAMT_W cycles from input transfer to out_valid (5 @ WIDTH=32).
//     Latency is independent of shift amount and mode.
//   - Throughput: 1 op/cycle while out_ready=1. Results leave in issue order.
//   - Fill per mode:
//       SLL: zeros in at LSB
//       SRL: zeros in at MSB
//       SRA: copies of original operand bit WIDTH-1 in at MSB
//       ROR: bits leaving at LSB re-enter at MSB
//   - shamt=0 returns the operand unchanged in every mode.
//   - Reset (any cycle, including mid-stream):
//       all stage valid bits and data registers <= 0 next edge
//       out_valid=0, data_result=0, in_ready=1
//       in-flight ops are discarded
//   - Reset has priority over stall and input.
//   - No arithmetic beyond shifting; no overflow flag.
// CONFIGURATION
//   SHIFTER_ROTATE_EN defined:
//     ctrl_mode=11 performs rotate-right by ctrl_shiftamt.
//   SHIFTER_ROTATE_EN undefined:
//     ctrl_mode=11 decodes as SLL; no rotate datapath is instantiated.
//   All other modes, latency and handshake are identical with or without the macro.
// TESTING (WIDTH=32)
//   1. SLL: A=0x00000001, shamt=31, out_ready=1
//      -> out_valid exactly 5 cycles later, data_result=0x80000000.
//   2. SRA vs SRL: A=0x80000000, shamt=4
//      -> SRA result 0xF8000000, SRL result 0x08000000; shamt=0 -> 0x80000000.
//   3. Stream: 8 back-to-back ops, A=i, SLL by i (i=0..7), out_ready=1
//      -> 8 consecutive out_valid cycles starting cycle 5, results i<<i in order.
//   4. Backpressure: 5 ops in flight, then out_ready=0 for 4 cycles
//      -> in_ready=0 and data_result frozen; after release, all 5 results in order,
//         none lost or duplicated.
//   5. Rotate: A=0x000000F1, mode=11, shamt=4
//      -> with SHIFTER_ROTATE_EN: 0x1000000F
//      -> without SHIFTER_ROTATE_EN: 0x00000F10.
//   6. Reset with 3 ops in flight
//      -> next cycle out_valid=0, data_result=0, in_ready=1;
//         no stale result ever appears after reset deasserts.

Source files
------------

// File: rtl/pipelined_shifter.sv
// rtl/pipelined_shifter.sv - fully pipelined barrel shifter (SLL/SRL/SRA, optional ROR)
//
// Purpose:
//    One register stage per shift-amount bit. Stage k shifts by 2^k when bit k of
//    the carried shift amount is set, LSB stage first. Latency is SHAMT_W cycles
//    regardless of mode or amount. A single global advance enable moves the whole
//    pipeline or freezes it; bubbles are not collapsed while stalled.
//
// Configuration macro:
//    SHIFTER_ROTATE_EN  - when defined, ctrl_mode=11 rotates right; otherwise it
//                         decodes as SLL and no rotate datapath exists.
//
// Ports:
//    clock          in   1        rising-edge clock
//    reset          in   1        synchronous, active-high reset
//    in_valid       in   1        operand/control valid this cycle
//    in_ready       out  1        shifter accepts input this cycle
//    data_operandA  in   WIDTH    value to shift
//    ctrl_shiftamt  in   SHAMT_W  shift amount, 0..WIDTH-1
//    ctrl_mode      in   2        00 SLL, 01 SRL, 10 SRA, 11 ROR/SLL
//    out_valid      out  1        data_result valid
//    out_ready      in   1        consumer accepts result this cycle
//    data_result    out  WIDTH    shifted result
module pipelined_shifter #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   data_operandA,
   input  logic [SHAMT_W-1:0] ctrl_shiftamt,
   input  logic [1:0]         ctrl_mode,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   data_result
);

   localparam logic [1:0] MODE_SRL = 2'b01;
   localparam logic [1:0] MODE_SRA = 2'b10;
`ifdef SHIFTER_ROTATE_EN
   localparam logic [1:0] MODE_ROR = 2'b11;
`endif

   logic [WIDTH-1:0]   stage_data  [SHAMT_W];
   logic [SHAMT_W-1:0] stage_shamt [SHAMT_W];
   logic [1:0]         stage_mode  [SHAMT_W];
   logic [SHAMT_W-1:0] stage_valid;

   // Per-stage inputs: stage 0 sees the ports, stage k sees stage k-1's register.
   logic [WIDTH-1:0]   src_data  [SHAMT_W];
   logic [SHAMT_W-1:0] src_shamt [SHAMT_W];
   logic [1:0]         src_mode  [SHAMT_W];
   logic [SHAMT_W-1:0] src_valid;
   logic [WIDTH-1:0]   next_data [SHAMT_W];

   logic adv;

   // SRA stays correct across stages because every arithmetic stage preserves
   // the MSB, so the original sign keeps propagating down the pipeline.
   function automatic logic [WIDTH-1:0] shift_by(input logic [WIDTH-1:0] d,
                                                 input logic [1:0]       mode,
                                                 input int unsigned      amt);
`ifdef SHIFTER_ROTATE_EN
      logic [2*WIDTH-1:0] dd;
`endif
      case (mode)
         MODE_SRL: return d >> amt;
         MODE_SRA: return $signed(d) >>> amt;
`ifdef SHIFTER_ROTATE_EN
         MODE_ROR: begin
            dd = {d, d} >> amt;
            return dd[WIDTH-1:0];
         end
`endif
         default:  return d << amt;
      endcase
   endfunction

   assign out_valid   = stage_valid[SHAMT_W-1];
   assign data_result = stage_data[SHAMT_W-1];
   assign adv         = out_ready | ~out_valid;
   assign in_ready    = adv;

   always_comb begin
      src_data[0]  = data_operandA;
      src_shamt[0] = ctrl_shiftamt;
      src_mode[0]  = ctrl_mode;
      src_valid[0] = in_valid;
      for (int k = 1; k < SHAMT_W; k++) begin
         src_data[k]  = stage_data[k-1];
         src_shamt[k] = stage_shamt[k-1];
         src_mode[k]  = stage_mode[k-1];
         src_valid[k] = stage_valid[k-1];
      end
      for (int k = 0; k < SHAMT_W; k++) begin
         next_data[k] = src_shamt[k][k] ? shift_by(src_data[k], src_mode[k], 1 << k)
                                        : src_data[k];
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         stage_valid <= '0;
         for (int k = 0; k < SHAMT_W; k++) begin
            stage_data[k]  <= '0;
            stage_shamt[k] <= '0;
            stage_mode[k]  <= '0;
         end
      end else if (adv) begin
         stage_valid <= src_valid;
         for (int k = 0; k < SHAMT_W; k++) begin
            stage_data[k]  <= next_data[k];
            stage_shamt[k] <= src_shamt[k];
            stage_mode[k]  <= src_mode[k];
         end
      end
   end

endmodule

// File: tb/tb_pipelined_shifter.sv
// tb/tb_pipelined_shifter.sv - directed self-checking bench for pipelined_shifter
module tb_pipelined_shifter;

   logic        clock = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] data_operandA;
   logic [4:0]  ctrl_shiftamt;
   logic [1:0]  ctrl_mode;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] data_result;

   int checks = 0;
   int errors = 0;

   pipelined_shifter #(.WIDTH(32)) dut (
      .clock         (clock),
      .reset         (reset),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .data_operandA (data_operandA),
      .ctrl_shiftamt (ctrl_shiftamt),
      .ctrl_mode     (ctrl_mode),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .data_result   (data_result)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Issue one op into an empty pipeline and wait (bounded) for its result.
   task automatic issue_and_wait(input logic [31:0] a, input logic [4:0] s,
                                 input logic [1:0] m,
                                 output logic [31:0] res, output int lat);
      in_valid = 1'b1; data_operandA = a; ctrl_shiftamt = s; ctrl_mode = m;
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin
         tick();
         lat++;
      end
      res = data_result;
      tick();
   endtask

   task automatic test_reset();
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      data_operandA = '0; ctrl_shiftamt = '0; ctrl_mode = '0;
      tick(); tick();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid);
      end
      checks++;
      if (data_result !== 32'h0) begin
         errors++; $display("FAIL reset_data got %h exp 00000000", data_result);
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready);
      end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_sll();
      logic [31:0] r; int lat;
      issue_and_wait(32'h0000_0001, 5'd31, 2'b00, r, lat);
      checks++;
      if (lat !== 5) begin errors++; $display("FAIL sll_latency got %0d exp 5", lat); end
      checks++;
      if (r !== 32'h8000_0000) begin errors++; $display("FAIL sll_31 got %h exp 80000000", r); end
   endtask

   task automatic test_sra_srl();
      logic [31:0] r; int lat;
      logic [31:0] av [6] = '{32'h8000_0000, 32'h8000_0000, 32'h7000_0000,
                              32'hFFFF_FFFF, 32'hFFFF_FFF0, 32'h8000_0000};
      logic [4:0]  sv [6] = '{5'd4, 5'd4, 5'd4, 5'd31, 5'd31, 5'd0};
      logic [1:0]  mv [6] = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10};
      logic [31:0] ev [6] = '{32'hF800_0000, 32'h0800_0000, 32'h0700_0000,
                              32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000};
      for (int i = 0; i < 6; i++) begin
         issue_and_wait(av[i], sv[i], mv[i], r, lat);
         checks++;
         if (r !== ev[i] || lat !== 5) begin
            errors++;
            $display("FAIL shift_vec%0d got %h lat %0d exp %h lat 5", i, r, lat, ev[i]);
         end
      end
      for (int m = 0; m < 4; m++) begin
         issue_and_wait(32'h8000_0000, 5'd0, 2'(m), r, lat);
         checks++;
         if (r !== 32'h8000_0000) begin
            errors++; $display("FAIL shamt0_mode%0d got %h exp 80000000", m, r);
         end
      end
   endtask

   task automatic test_rotate();
      logic [31:0] r; int lat; logic [31:0] exp_r;
`ifdef SHIFTER_ROTATE_EN
      exp_r = 32'h1000_000F;
`else
      exp_r = 32'h0000_0F10;
`endif
      issue_and_wait(32'h0000_00F1, 5'd4, 2'b11, r, lat);
      checks++;
      if (r !== exp_r || lat !== 5) begin
         errors++; $display("FAIL rotate got %h lat %0d exp %h lat 5", r, lat, exp_r);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] ev [8] = '{32'h0, 32'h2, 32'h8, 32'h18, 32'h40, 32'hA0, 32'h180, 32'h380};
      int idx = 0;
      out_ready = 1'b1;
      for (int cyc = 0; cyc < 16; cyc++) begin
         if (cyc < 8) begin
            in_valid = 1'b1; data_operandA = 32'(cyc); ctrl_shiftamt = 5'(cyc);
            ctrl_mode = 2'b00;
         end else begin
            in_valid = 1'b0;
         end
         tick();
         checks++;
         if (out_valid !== (cyc >= 4 && cyc < 12)) begin
            errors++; $display("FAIL stream_valid cyc %0d got %b", cyc, out_valid);
         end
         if (out_valid === 1'b1 && idx < 8) begin
            checks++;
            if (data_result !== ev[idx]) begin
               errors++; $display("FAIL stream_data%0d got %h exp %h", idx, data_result, ev[idx]);
            end
            idx++;
         end
      end
      checks++;
      if (idx !== 8) begin errors++; $display("FAIL stream_count got %0d exp 8", idx); end
   endtask

   task automatic test_backpressure();
      logic [31:0] av [5] = '{32'h100, 32'h100, 32'h8000_0000, 32'h1, 32'hF000_0000};
      logic [4:0]  sv [5] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4};
      logic [1:0]  mv [5] = '{2'b00, 2'b01, 2'b10, 2'b00, 2'b01};
      logic [31:0] ev [5] = '{32'h100, 32'h80, 32'hE000_0000, 32'h8, 32'h0F00_0000};
      int idx = 0;
      out_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         in_valid = 1'b1; data_operandA = av[k]; ctrl_shiftamt = sv[k]; ctrl_mode = mv[k];
         tick();
      end
      // Junk offered during the stall must not be accepted.
      data_operandA = 32'hDEAD_BEEF; ctrl_shiftamt = 5'd7; ctrl_mode = 2'b00;
      out_ready = 1'b0;
      #1;
      for (int c = 0; c < 4; c++) begin
         checks++;
         if (in_ready !== 1'b0 || out_valid !== 1'b1 || data_result !== ev[0]) begin
            errors++;
            $display("FAIL stall_cyc%0d in_ready %b out_valid %b data %h exp 0 1 %h",
                     c, in_ready, out_valid, data_result, ev[0]);
         end
         tick();
      end
      in_valid = 1'b0; out_ready = 1'b1;
      #1;
      for (int c = 0; c < 12; c++) begin
         if (out_valid === 1'b1) begin
            checks++;
            if (idx >= 5) begin
               errors++; $display("FAIL bp_extra got %h exp none", data_result);
            end else if (data_result !== ev[idx]) begin
               errors++; $display("FAIL bp_data%0d got %h exp %h", idx, data_result, ev[idx]);
            end
            idx++;
         end
         tick();
      end
      checks++;
      if (idx !== 5) begin errors++; $display("FAIL bp_count got %0d exp 5", idx); end
   endtask

   task automatic test_reset_midstream();
      int stale = 0;
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         in_valid = 1'b1; data_operandA = 32'h1234_5678 + k; ctrl_shiftamt = 5'd1;
         ctrl_mode = 2'b00;
         tick();
      end
      in_valid = 1'b0; reset = 1'b1;
      tick();
      checks++;
      if (out_valid !== 1'b0 || data_result !== 32'h0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL midreset out_valid %b data %h in_ready %b exp 0 00000000 1",
                  out_valid, data_result, in_ready);
      end
      reset = 1'b0;
      for (int c = 0; c < 10; c++) begin
         tick();
         if (out_valid !== 1'b0) stale++;
      end
      checks++;
      if (stale !== 0) begin errors++; $display("FAIL midreset_stale got %0d exp 0", stale); end
   endtask

   initial begin
      test_reset();
      test_sll();
      test_sra_srl();
      test_rotate();
      test_back_to_back();
      test_backpressure();
      test_reset_midstream();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
